// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM period / duty-cycle decoder.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_MEAS  = 2'd1,
    ST_STUCK = 2'd2
  } pwm_state_t;

  localparam int unsigned DUTY_W  = 7;
  localparam int unsigned DIV_LAT = 8;

endpackage

// File: rtl/pwm_div.sv
// Restoring divider producing a DUTY_W-bit quotient, one bit per cycle.
module pwm_div
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 24
) (
  input  logic                      clk_pwm,
  input  logic                      clr_pwm,
  input  logic                      start,
  input  logic [CNT_W+DUTY_W-1:0]   dividend,
  input  logic [CNT_W-1:0]          divisor,
  output logic                      done,
  output logic [DUTY_W-1:0]         quotient
);

  localparam int unsigned NUM_W  = CNT_W + DUTY_W;
  localparam int unsigned STEP_W = $clog2(DUTY_W);

  logic [NUM_W-1:0]  rem, dsh;
  logic [NUM_W-1:0]  rem_in_c, dsh_in_c, rem_nxt_c;
  logic              bit_c;
  logic [DUTY_W-1:0] q;
  logic [STEP_W-1:0] steps;
  logic              busy;

  // The start cycle works on the fresh operands so the MSB is resolved on the load edge.
  always_comb begin
    rem_in_c  = start ? dividend : rem;
    dsh_in_c  = start ? (NUM_W'(divisor) << (DUTY_W - 1)) : dsh;
    bit_c     = (rem_in_c >= dsh_in_c);
    rem_nxt_c = bit_c ? (rem_in_c - dsh_in_c) : rem_in_c;
  end

  always_ff @(posedge clk_pwm) begin
    if (clr_pwm) begin
      rem      <= '0;
      dsh      <= '0;
      q        <= '0;
      steps    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem   <= rem_nxt_c;
        dsh   <= dsh_in_c >> 1;
        q     <= DUTY_W'(bit_c);
        steps <= STEP_W'(DUTY_W - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        rem   <= rem_nxt_c;
        dsh   <= dsh >> 1;
        q     <= {q[DUTY_W-2:0], bit_c};
        steps <= steps - STEP_W'(1);
        if (steps == STEP_W'(1)) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          quotient <= {q[DUTY_W-2:0], bit_c};
        end
      end
    end
  end

endmodule

// File: rtl/pwm_decode.sv
// Measures period, high time and duty cycle of an asynchronous PWM input,
// and flags a stuck input or a capture lost to a busy divider.
module pwm_decode
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned TIMEOUT = 2**24 - 1
) (
  input  logic                clk_pwm,
  input  logic                clr_pwm,
  input  logic                pwm_in,
  output logic [CNT_W-1:0]    period,
  output logic [CNT_W-1:0]    high_time,
  output logic [DUTY_W-1:0]   duty,
  output logic                valid,
  output logic                stuck,
  output logic                ovr
);

  localparam int unsigned NUM_W = CNT_W + DUTY_W;
  localparam int unsigned LAT_W = $clog2(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(TIMEOUT - 1);

  pwm_state_t        state, state_nxt;
  logic              sync1, s, s_d, rise_c;
  logic [CNT_W-1:0]  per_cnt, hi_cnt, per_smp, hi_smp;
  logic [LAT_W-1:0]  busy_cnt;
  logic              capture_c, drop_c, timeout_c, leave_stuck_c;
  logic              stuck_pend, pend_hi;
  logic              div_done;
  logic [DUTY_W-1:0] div_q;

  assign rise_c = s & ~s_d;

  always_ff @(posedge clk_pwm) begin
    if (clr_pwm) state <= ST_ARM;
    else         state <= state_nxt;
  end

  // Only a rise seen while measuring closes a period; other rises just arm.
  always_comb begin
    state_nxt     = state;
    capture_c     = 1'b0;
    drop_c        = 1'b0;
    timeout_c     = 1'b0;
    leave_stuck_c = 1'b0;
    case (state)
      ST_ARM: begin
        if (rise_c) state_nxt = ST_MEAS;
      end
      ST_MEAS: begin
        if (rise_c) begin
          if (busy_cnt != '0) drop_c    = 1'b1;
          else                capture_c = 1'b1;
        end else if (per_cnt == TMO_M1) begin
          timeout_c = 1'b1;
          state_nxt = ST_STUCK;
        end
      end
      ST_STUCK: begin
        if (rise_c) begin
          leave_stuck_c = 1'b1;
          state_nxt     = ST_MEAS;
        end
      end
      default: state_nxt = ST_ARM;
    endcase
  end

  pwm_div #(.CNT_W(CNT_W)) u_div (
    .clk_pwm  (clk_pwm),
    .clr_pwm  (clr_pwm),
    .start    (capture_c),
    .dividend (NUM_W'(hi_cnt) * NUM_W'(100)),
    .divisor  (per_cnt),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk_pwm) begin
    if (clr_pwm) begin
      sync1      <= 1'b0;
      s          <= 1'b0;
      s_d        <= 1'b0;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      per_smp    <= '0;
      hi_smp     <= '0;
      busy_cnt   <= '0;
      stuck_pend <= 1'b0;
      pend_hi    <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      duty       <= '0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      s     <= sync1;
      s_d   <= s;

      if (rise_c) begin
        per_cnt <= CNT_W'(1);
        hi_cnt  <= CNT_W'(1);
      end else begin
        if (per_cnt != TMO)          per_cnt <= per_cnt + CNT_W'(1);
        if (s && hi_cnt != CNT_MAX)  hi_cnt  <= hi_cnt + CNT_W'(1);
      end

      // busy_cnt spans the cycles between a capture and its result.
      if (capture_c) begin
        per_smp  <= per_cnt;
        hi_smp   <= hi_cnt;
        busy_cnt <= LAT_W'(DIV_LAT - 1);
      end else if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - LAT_W'(1);
      end

      if (drop_c) ovr <= 1'b1;

      // A divider result wins a tie with the timeout; the stuck report follows a cycle later.
      valid <= 1'b0;
      if (div_done) begin
        period    <= per_smp;
        high_time <= hi_smp;
        duty      <= div_q;
        valid     <= 1'b1;
        if (timeout_c) begin
          stuck_pend <= 1'b1;
          pend_hi    <= s;
        end
      end else if (timeout_c || stuck_pend) begin
        period     <= '0;
        high_time  <= '0;
        duty       <= (timeout_c ? s : pend_hi) ? DUTY_W'(100) : '0;
        valid      <= 1'b1;
        stuck      <= 1'b1;
        stuck_pend <= 1'b0;
      end

      if (leave_stuck_c) begin
        stuck      <= 1'b0;
        stuck_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_decode.sv
// Randomized bench for pwm_decode against an event-level reference model.
module tb_pwm_decode;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1500;
  localparam int LAT     = 8;
  localparam int MAXC    = 60000;

  logic             clk_pwm = 1'b0;
  logic             clr_pwm = 1'b1;
  logic             pwm_in  = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic [6:0]       duty;
  logic             valid, stuck, ovr;

  pwm_decode #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_pwm   (clk_pwm),
    .clr_pwm   (clr_pwm),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .duty      (duty),
    .valid     (valid),
    .stuck     (stuck),
    .ovr       (ovr)
  );

  always #5 clk_pwm = ~clk_pwm;

  typedef struct {
    int at;
    int per;
    int hi;
    int duty;
    bit stk;
  } ev_t;

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  bit  inp_h [MAXC];
  bit  clr_h [MAXC];
  bit  s_h   [MAXC];
  ev_t evq [$];

  bit  m_meas = 0, m_stuck = 0;
  int  m_last_rise = 0, m_hi = 0, m_last_acc = -100, m_ovr_at = -1, m_sclr_at = -1;
  int  e_per = 0, e_hi = 0, e_duty = 0;
  bit  e_valid = 0, e_stuck = 0, e_ovr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs for cycle c, from the edge history and the measurement rules.
  task automatic model_cycle(input int c);
    bit  sv, rise;
    int  p;
    ev_t ev;
    if (clr_h[c-1]) begin
      m_meas = 0; m_stuck = 0; m_hi = 0; m_last_rise = 0;
      m_last_acc = -100; m_ovr_at = -1; m_sclr_at = -1;
      evq.delete();
      e_per = 0; e_hi = 0; e_duty = 0; e_valid = 0; e_stuck = 0; e_ovr = 0;
    end
    if (c < 2)                          sv = 0;
    else if (clr_h[c-1] || clr_h[c-2])  sv = 0;
    else                                sv = inp_h[c-2];
    s_h[c] = sv;
    rise = sv && !s_h[c-1];

    e_valid = 0;
    if (evq.size() > 0 && evq[0].at == c) begin
      ev = evq.pop_front();
      e_valid = 1; e_per = ev.per; e_hi = ev.hi; e_duty = ev.duty;
      if (ev.stk) e_stuck = 1;
    end
    if (c == m_ovr_at)  e_ovr = 1;
    if (c == m_sclr_at) e_stuck = 0;

    if (rise) begin
      if (m_meas) begin
        if (c - m_last_acc < LAT) m_ovr_at = c + 1;
        else begin
          p  = c - m_last_rise;
          ev = '{at: c + LAT, per: p, hi: m_hi, duty: (m_hi * 100) / p, stk: 1'b0};
          evq.push_back(ev);
          m_last_acc = c;
        end
      end
      if (m_stuck) m_sclr_at = c + 1;
      m_meas = 1; m_stuck = 0; m_last_rise = c; m_hi = 0;
    end else if (m_meas && (c + 1 - m_last_rise == TIMEOUT)) begin
      ev = '{at: c + 1, per: 0, hi: 0, duty: sv ? 100 : 0, stk: 1'b1};
      if (evq.size() > 0 && evq[$].at == c + 1) ev.at = c + 2;
      evq.push_back(ev);
      m_meas = 0; m_stuck = 1;
    end
    if (sv) m_hi++;
  endtask

  task automatic step(input logic v, input logic r);
    @(posedge clk_pwm);
    #1;
    cyc++;
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget cyc=%0d got=%0d exp=%0d", cyc, cyc, MAXC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    pwm_in = v; clr_pwm = r;
    inp_h[cyc] = v; clr_h[cyc] = r;
    model_cycle(cyc);
    @(negedge clk_pwm);
    check("valid",     32'(valid),     32'(e_valid));
    check("stuck",     32'(stuck),     32'(e_stuck));
    check("ovr",       32'(ovr),       32'(e_ovr));
    check("period",    32'(period),    32'(e_per));
    check("high_time", 32'(high_time), 32'(e_hi));
    check("duty",      32'(duty),      32'(e_duty));
  endtask

  task automatic pulse(input int per, input int hi);
    for (int i = 0; i < per; i++) step(i < hi, 1'b0);
  endtask

  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) step(v, 1'b0);
  endtask

  task automatic rst(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  initial begin
    int per, hi;
    inp_h[0] = 0; clr_h[0] = 1; s_h[0] = 0;

    rst(3);
    idle(5, 1'b0);
    for (int k = 0; k < 4; k++) pulse(1000, 900);

    rst(2);
    idle(4, 1'b0);
    for (int k = 0; k < 8; k++) pulse(3, 1);
    idle(20, 1'b0);

    rst(2);
    for (int k = 0; k < 10; k++) pulse(4, 2);
    idle(30, 1'b0);
    for (int k = 0; k < 3; k++) pulse(50, 20);
    rst(1);

    for (int k = 0; k < 30; k++) begin
      per = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 12)) : int'($urandom_range(13, 700));
      hi  = int'($urandom_range(1, per - 1));
      pulse(per, hi);
    end

    pulse(100, 40);
    idle(TIMEOUT + 100, 1'b1);
    idle(5, 1'b0);
    for (int k = 0; k < 3; k++) pulse(100, 50);
    idle(TIMEOUT + 50, 1'b0);
    for (int k = 0; k < 3; k++) pulse(60, 15);

    for (int k = 0; k < 3; k++) pulse(20, 10);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    idle(15, 1'b1);
    idle(5, 1'b0);
    for (int k = 0; k < 3; k++) pulse(30, 10);

    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 5) == 0) rst(int'($urandom_range(1, 3)));
      per = int'($urandom_range(2, 300));
      hi  = int'($urandom_range(1, per - 1));
      pulse(per, hi);
    end

    idle(20, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
